inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the width of PC, SRAM address and instruction data.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port pc_i  input  WIDTH  current fetch PC from the PC register.
REQ-005 The block SHALL have port pc_stall_o  output  1  hold the PC register when 1; PC advances only when 0.
REQ-006 The block SHALL have port flush_i  input  1  discard all in-flight and buffered fetch work.
REQ-007 The block SHALL have port stall_d_i  input  1  decode stage cannot accept an instruction this cycle.
REQ-008 The block SHALL have ports inst_sram_req  output  1  and inst_sram_addr  output  WIDTH  SRAM read request and word address.
REQ-009 The block SHALL have ports inst_sram_addr_ok  input  1, inst_sram_data_ok  input  1 and inst_sram_rdata  input  WIDTH  SRAM handshake and read data.
REQ-010 The block SHALL have ports if_valid_o  output  1, if_pc_o  output  WIDTH, if_inst_o  output  WIDTH and if_adel_o  output  1  registered instruction, PC and address-error flag to decode.

Function
REQ-011 The block SHALL implement states REQ, WAIT_DATA, HOLD and DISCARD, with at most one outstanding SRAM read.
REQ-012 In REQ, inst_sram_req SHALL be 1 and inst_sram_addr SHALL equal {pc_i[WIDTH-1:2],2'b00}, stable until addr_ok.
REQ-013 REQ with addr_ok=1 SHALL move to WAIT_DATA; inst_sram_req SHALL be 0 in every state other than REQ.
REQ-014 WAIT_DATA with data_ok=1 and stall_d_i=0 SHALL load if_inst_o=rdata, if_pc_o=pc_i, if_valid_o=1 on the next edge and return to REQ.
REQ-015 WAIT_DATA with data_ok=1 and stall_d_i=1 SHALL capture rdata in an internal one-word buffer and move to HOLD.
REQ-016 HOLD with stall_d_i=0 SHALL deliver the buffered word as in REQ-014 and return to REQ.
REQ-017 pc_stall_o SHALL be 0 only in a delivery cycle (REQ-014, REQ-016, or REQ-031 with stall_d_i=0), otherwise 1.
REQ-018 With stall_d_i=1, if_valid_o, if_pc_o, if_inst_o and if_adel_o SHALL hold their values.
REQ-019 With stall_d_i=0 and no delivery, if_valid_o SHALL become 0 on the next edge (bubble).
REQ-020 flush_i=1 SHALL clear if_valid_o on the next edge, overriding REQ-014, REQ-016, REQ-018 and REQ-031.
REQ-021 flush_i in REQ without addr_ok SHALL stay in REQ; with addr_ok SHALL go to DISCARD.
REQ-022 flush_i in WAIT_DATA without data_ok SHALL go to DISCARD; with data_ok SHALL drop the data and go to REQ.
REQ-023 flush_i in HOLD SHALL drop the buffer and go to REQ.
REQ-024 DISCARD SHALL ignore further flush_i, wait for data_ok, drop the data, then go to REQ.
REQ-025 Best-case latency: addr_ok in cycle N, data_ok in N+1, if_valid_o=1 in N+2; throughput one instruction per two cycles.

Reset
REQ-026 While resetn=0: state REQ, inst_sram_req=0, pc_stall_o=1, if_valid_o=0, if_pc_o=0, if_inst_o=0, if_adel_o=0, buffer cleared.
REQ-027 The first edge after resetn rises SHALL find inst_sram_req=1 with the address from pc_i.
REQ-028 Reset asserted mid-transaction SHALL abandon it; any data_ok after release without a request issued since release SHALL be ignored.

Configuration
REQ-029 Macro INST_FETCH_ADEL_EN SHALL compile in address-error detection.
REQ-030 With INST_FETCH_ADEL_EN, pc_i[1:0]!=0 in REQ SHALL suppress inst_sram_req.
REQ-031 With INST_FETCH_ADEL_EN, in the REQ-030 condition with stall_d_i=0, the next edge SHALL deliver if_valid_o=1, if_adel_o=1, if_inst_o=0 and if_pc_o=pc_i; with stall_d_i=1 the block SHALL stay in REQ.
REQ-032 Without INST_FETCH_ADEL_EN, pc_i[1:0] SHALL be ignored and if_adel_o SHALL be constant 0.

Verification
REQ-033 Reset release, pc_i=32'hbfc00000, addr_ok same cycle, data_ok next with rdata=32'h24080001 -> if_valid_o=1, if_pc_o=bfc00000, if_inst_o=24080001 two cycles after request.
REQ-034 addr_ok delayed 3 cycles -> inst_sram_req and inst_sram_addr stable for 3 cycles, pc_stall_o=1 throughout.
REQ-035 stall_d_i=1 across data_ok with rdata=32'h8c020004 -> HOLD; stall_d_i low 2 cycles later -> if_inst_o=8c020004 one edge later, exactly once.
REQ-036 flush_i in the addr_ok cycle, data_ok 2 cycles later -> no delivery, next request uses post-flush pc_i=32'hbfc00380.
REQ-037 INST_FETCH_ADEL_EN defined, pc_i=32'hbfc00002 -> inst_sram_req=0, if_valid_o=1, if_adel_o=1, if_inst_o=0; without macro -> request issued to bfc00000.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch front end: one outstanding SRAM read, a one-word hold buffer for decode stalls, and flush handling.
// Optional address-error detection is compiled in with INST_FETCH_ADEL_EN.
module inst_fetch #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] pc_i,
    output logic             pc_stall_o,
    input  logic             flush_i,
    input  logic             stall_d_i,
    output logic             inst_sram_req,
    output logic [WIDTH-1:0] inst_sram_addr,
    input  logic             inst_sram_addr_ok,
    input  logic             inst_sram_data_ok,
    input  logic [WIDTH-1:0] inst_sram_rdata,
    output logic             if_valid_o,
    output logic [WIDTH-1:0] if_pc_o,
    output logic [WIDTH-1:0] if_inst_o,
    output logic             if_adel_o
);

    typedef enum logic [1:0] {
        REQ,
        WAIT_DATA,
        HOLD,
        DISCARD
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] buffer;
    logic             adel;
    logic             wait_hit;
    logic             deliver;

`ifdef INST_FETCH_ADEL_EN
    assign adel = (state == REQ) && (pc_i[1:0] != 2'b00);
`else
    logic pc_unused;
    assign pc_unused = ^pc_i[1:0];
    assign adel      = 1'b0;
`endif

    assign wait_hit       = (state == WAIT_DATA) && inst_sram_data_ok;
    assign deliver        = resetn && !flush_i && !stall_d_i
                            && (wait_hit || (state == HOLD) || adel);
    assign pc_stall_o     = !deliver;
    // Gating with resetn keeps the request low while reset is held even though the state already reads REQ.
    assign inst_sram_req  = resetn && (state == REQ) && !adel;
    assign inst_sram_addr = {pc_i[WIDTH-1:2], 2'b00};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= REQ;
            buffer     <= '0;
            if_valid_o <= 1'b0;
            if_pc_o    <= '0;
            if_inst_o  <= '0;
            if_adel_o  <= 1'b0;
        end else begin
            if (flush_i) begin
                if_valid_o <= 1'b0;
            end else if (deliver) begin
                if_valid_o <= 1'b1;
                if_pc_o    <= pc_i;
                if_adel_o  <= adel;
                if (adel)
                    if_inst_o <= '0;
                else if (state == HOLD)
                    if_inst_o <= buffer;
                else
                    if_inst_o <= inst_sram_rdata;
            end else if (!stall_d_i) begin
                if_valid_o <= 1'b0;
            end

            case (state)
                REQ: begin
                    if (!adel && inst_sram_addr_ok)
                        state <= flush_i ? DISCARD : WAIT_DATA;
                end
                WAIT_DATA: begin
                    if (inst_sram_data_ok) begin
                        if (flush_i) begin
                            state <= REQ;
                        end else if (stall_d_i) begin
                            buffer <= inst_sram_rdata;
                            state  <= HOLD;
                        end else begin
                            state <= REQ;
                        end
                    end else if (flush_i) begin
                        state <= DISCARD;
                    end
                end
                HOLD: begin
                    if (flush_i || !stall_d_i) begin
                        buffer <= '0;
                        state  <= REQ;
                    end
                end
                DISCARD: begin
                    if (inst_sram_data_ok)
                        state <= REQ;
                end
                default: state <= REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch; every expected value is worked out by hand from the fetch protocol.
module tb_inst_fetch;

    logic        clk;
    logic        resetn;
    logic [31:0] pc_i;
    logic        pc_stall_o;
    logic        flush_i;
    logic        stall_d_i;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_adel_o;

    int errorCount = 0;
    int checkCount = 0;

    inst_fetch #(.WIDTH(32)) dut (
        .clk(clk),
        .resetn(resetn),
        .pc_i(pc_i),
        .pc_stall_o(pc_stall_o),
        .flush_i(flush_i),
        .stall_d_i(stall_d_i),
        .inst_sram_req(inst_sram_req),
        .inst_sram_addr(inst_sram_addr),
        .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .if_valid_o(if_valid_o),
        .if_pc_o(if_pc_o),
        .if_inst_o(if_inst_o),
        .if_adel_o(if_adel_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle's worth of inputs and let combinational outputs settle before checking them.
    task automatic applyStimulus(input logic [31:0] pc, input logic aok, input logic dok,
                                 input logic [31:0] rdata, input logic stall, input logic flush);
        pc_i              = pc;
        inst_sram_addr_ok = aok;
        inst_sram_data_ok = dok;
        inst_sram_rdata   = rdata;
        stall_d_i         = stall;
        flush_i           = flush;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        applyStimulus(32'hbfc00000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("rst_req", {31'b0, inst_sram_req}, 32'd0);
        checkOutput("rst_pcstall", {31'b0, pc_stall_o}, 32'd1);
        checkOutput("rst_valid", {31'b0, if_valid_o}, 32'd0);
        checkOutput("rst_pc", if_pc_o, 32'h0);
        checkOutput("rst_inst", if_inst_o, 32'h0);
        checkOutput("rst_adel", {31'b0, if_adel_o}, 32'd0);

        // Best-case fetch straight out of reset.
        resetn = 1'b1;
        applyStimulus(32'hbfc00000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("first_req", {31'b0, inst_sram_req}, 32'd1);
        checkOutput("first_addr", inst_sram_addr, 32'hbfc00000);
        checkOutput("first_pcstall", {31'b0, pc_stall_o}, 32'd1);
        tick();
        applyStimulus(32'hbfc00000, 1'b0, 1'b1, 32'h24080001, 1'b0, 1'b0);
        checkOutput("wait_req", {31'b0, inst_sram_req}, 32'd0);
        checkOutput("deliver_pcstall", {31'b0, pc_stall_o}, 32'd0);
        tick();
        checkOutput("d1_valid", {31'b0, if_valid_o}, 32'd1);
        checkOutput("d1_pc", if_pc_o, 32'hbfc00000);
        checkOutput("d1_inst", if_inst_o, 32'h24080001);

        // addr_ok held off for three cycles.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'hbfc00004, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            checkOutput($sformatf("slow_req%0d", i), {31'b0, inst_sram_req}, 32'd1);
            checkOutput($sformatf("slow_addr%0d", i), inst_sram_addr, 32'hbfc00004);
            checkOutput($sformatf("slow_pcstall%0d", i), {31'b0, pc_stall_o}, 32'd1);
            tick();
            checkOutput($sformatf("slow_bubble%0d", i), {31'b0, if_valid_o}, 32'd0);
        end
        applyStimulus(32'hbfc00004, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();

        // Decode stalls across data_ok: the word waits in HOLD.
        applyStimulus(32'hbfc00004, 1'b0, 1'b1, 32'h8c020004, 1'b1, 1'b0);
        checkOutput("stall_pcstall", {31'b0, pc_stall_o}, 32'd1);
        tick();
        checkOutput("hold_valid", {31'b0, if_valid_o}, 32'd0);
        applyStimulus(32'hbfc00004, 1'b0, 1'b0, 32'hffffffff, 1'b1, 1'b0);
        checkOutput("hold_req", {31'b0, inst_sram_req}, 32'd0);
        checkOutput("hold_pcstall", {31'b0, pc_stall_o}, 32'd1);
        tick();
        applyStimulus(32'hbfc00004, 1'b0, 1'b0, 32'hffffffff, 1'b0, 1'b0);
        checkOutput("hold_release_pcstall", {31'b0, pc_stall_o}, 32'd0);
        tick();
        checkOutput("hold_valid_out", {31'b0, if_valid_o}, 32'd1);
        checkOutput("hold_inst", if_inst_o, 32'h8c020004);
        checkOutput("hold_pc", if_pc_o, 32'hbfc00004);

        // Decode stall keeps the delivered word, then a bubble follows: delivered exactly once.
        applyStimulus(32'hbfc00008, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("stall_keep_valid", {31'b0, if_valid_o}, 32'd1);
        checkOutput("stall_keep_inst", if_inst_o, 32'h8c020004);
        applyStimulus(32'hbfc00008, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("once_valid", {31'b0, if_valid_o}, 32'd0);

        // Flush in the addr_ok cycle: the returning data is dropped.
        applyStimulus(32'hbfc00008, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("flush_req", {31'b0, inst_sram_req}, 32'd1);
        tick();
        applyStimulus(32'hbfc00380, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("discard_req", {31'b0, inst_sram_req}, 32'd0);
        tick();
        applyStimulus(32'hbfc00380, 1'b0, 1'b1, 32'hdeadbeef, 1'b0, 1'b1);
        checkOutput("discard_pcstall", {31'b0, pc_stall_o}, 32'd1);
        tick();
        checkOutput("discard_valid", {31'b0, if_valid_o}, 32'd0);
        applyStimulus(32'hbfc00380, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("post_flush_req", {31'b0, inst_sram_req}, 32'd1);
        checkOutput("post_flush_addr", inst_sram_addr, 32'hbfc00380);
        tick();
        applyStimulus(32'hbfc00380, 1'b0, 1'b1, 32'h11112222, 1'b0, 1'b0);
        tick();
        checkOutput("post_flush_pc", if_pc_o, 32'hbfc00380);
        checkOutput("post_flush_inst", if_inst_o, 32'h11112222);

        // Flush together with data_ok while decode stalls: valid clears and no HOLD is entered.
        applyStimulus(32'hbfc00384, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("pre_flush_valid", {31'b0, if_valid_o}, 32'd1);
        applyStimulus(32'hbfc00384, 1'b0, 1'b1, 32'h33334444, 1'b1, 1'b1);
        tick();
        checkOutput("flush_data_valid", {31'b0, if_valid_o}, 32'd0);
        applyStimulus(32'hbfc00400, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("flush_data_req", {31'b0, inst_sram_req}, 32'd1);

        // Reset mid-transaction: a stale data_ok after release is ignored.
        applyStimulus(32'hbfc00400, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        resetn = 1'b0;
        #1;
        checkOutput("midrst_req", {31'b0, inst_sram_req}, 32'd0);
        tick();
        resetn = 1'b1;
        applyStimulus(32'hbfc00400, 1'b0, 1'b1, 32'h55556666, 1'b0, 1'b0);
        checkOutput("stale_req", {31'b0, inst_sram_req}, 32'd1);
        checkOutput("stale_pcstall", {31'b0, pc_stall_o}, 32'd1);
        tick();
        checkOutput("stale_valid", {31'b0, if_valid_o}, 32'd0);
        applyStimulus(32'hbfc00400, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("stale_still_req", {31'b0, inst_sram_req}, 32'd1);

        // Misaligned PC.
        applyStimulus(32'hbfc00002, 1'b0, 1'b0, 32'h77778888, 1'b0, 1'b0);
`ifdef INST_FETCH_ADEL_EN
        checkOutput("adel_req", {31'b0, inst_sram_req}, 32'd0);
        checkOutput("adel_pcstall", {31'b0, pc_stall_o}, 32'd0);
        tick();
        checkOutput("adel_valid", {31'b0, if_valid_o}, 32'd1);
        checkOutput("adel_flag", {31'b0, if_adel_o}, 32'd1);
        checkOutput("adel_inst", if_inst_o, 32'h0);
        checkOutput("adel_pc", if_pc_o, 32'hbfc00002);
`else
        checkOutput("noadel_req", {31'b0, inst_sram_req}, 32'd1);
        checkOutput("noadel_addr", inst_sram_addr, 32'hbfc00000);
        applyStimulus(32'hbfc00002, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        applyStimulus(32'hbfc00002, 1'b0, 1'b1, 32'h77778888, 1'b0, 1'b0);
        tick();
        checkOutput("noadel_valid", {31'b0, if_valid_o}, 32'd1);
        checkOutput("noadel_flag", {31'b0, if_adel_o}, 32'd0);
        checkOutput("noadel_inst", if_inst_o, 32'h77778888);
`endif

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
